// File: rtl/snoopy_motion_pkg.sv
// Shared constants for the snoopy game datapath: course geometry, FSM encodings,
// and the x positions the score stage matches against.
package snoopy_motion_pkg;

  localparam logic [8:0] X_START  = 9'd20;
  localparam logic [8:0] X_END    = 9'd170;
  localparam logic [7:0] Y_GROUND = 8'd100;
  localparam logic [7:0] JUMP_H   = 8'd24;
  localparam logic [7:0] Y_APEX   = Y_GROUND - JUMP_H;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_RISE   = 3'd2;
  localparam logic [2:0] ST_FALL   = 3'd3;
  localparam logic [2:0] ST_OVER   = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  // Exact-match score thresholds; motion steps by 1 so none can be skipped.
  localparam int         NUM_SCORE = 3;
  localparam logic [NUM_SCORE-1:0][8:0] SCORE_X = {9'd150, 9'd100, 9'd60};

  function automatic logic is_active(input logic [2:0] st);
    return (st == ST_RUN) || (st == ST_RISE) || (st == ST_FALL);
  endfunction

endpackage

// File: rtl/btn_pulse.sv
// Button conditioner: two-flop synchroniser followed by a rising-edge detector.
// One pulse per press, visible in the cycle before the third edge after the press.
module btn_pulse (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  // [0],[1] synchroniser, [2] previous synchronised level
  logic [2:0] sh_q;

  always_ff @(posedge clock) begin
    if (!reset) sh_q <= '0;
    else        sh_q <= {sh_q[1:0], btn_i};
  end

  assign pulse_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/snoopy_motion.sv
// Player motion: run/jump FSM advanced by frame ticks, producing x_pos for the
// score stage and y_pos for the renderer. Freezes on collision or course end.
module snoopy_motion
  import snoopy_motion_pkg::*;
#(
  parameter int TICK_DIV = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       jump,
  input  logic       collide,
  output logic [8:0] x_pos,
  output logic [7:0] y_pos,
  output logic       running,
  output logic       game_over,
  output logic       finished
);

  localparam int NUM_BTN = 2;
  localparam int DIV_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [NUM_BTN-1:0] btn_raw, btn_p;
  logic               start_p, jump_p;

  assign btn_raw = {jump, start};
  assign start_p = btn_p[0];
  assign jump_p  = btn_p[1];

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_pulse u_btn (
      .clock   (clock),
      .reset   (reset),
      .btn_i   (btn_raw[gi]),
      .pulse_o (btn_p[gi])
    );
  end

  logic [2:0]       state_q, state_d;
  logic [8:0]       x_q, x_d;
  logic [7:0]       y_q, y_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             step;

  // Horizontal motion continues through a jump; collide and course end freeze it.
  assign step = is_active(state_q) && frame_tick && !collide && (x_q != X_END);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    div_d   = div_q;

    if (step) begin
      if (div_q == DIV_W'(TICK_DIV - 1)) begin
        div_d = '0;
        x_d   = x_q + 9'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: if (start_p) state_d = ST_RUN;
      ST_RUN, ST_RISE, ST_FALL: begin
        if (collide)              state_d = ST_OVER;
        else if (x_q == X_END)    state_d = ST_FINISH;
        else if (state_q == ST_RUN) begin
          if (jump_p) state_d = ST_RISE;
        end else if (frame_tick) begin
          if (state_q == ST_RISE) begin
            y_d = y_q - 8'd1;
            if (y_d == Y_APEX) state_d = ST_FALL;
          end else begin
            y_d = y_q + 8'd1;
            if (y_d == Y_GROUND) state_d = ST_RUN;
          end
        end
      end
      ST_OVER, ST_FINISH: begin
        if (state_q == ST_FINISH && frame_tick) y_d = Y_GROUND;
        // Restart skips IDLE so x drops straight back below the thresholds.
        if (start_p) begin
          state_d = ST_RUN;
          x_d     = X_START;
          y_d     = Y_GROUND;
          div_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      x_q     <= X_START;
      y_q     <= Y_GROUND;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      div_q   <= div_d;
    end
  end

  assign x_pos     = x_q;
  assign y_pos     = y_q;
  assign running   = is_active(state_q);
  assign game_over = (state_q == ST_OVER);
  assign finished  = (state_q == ST_FINISH);

endmodule
